xnor_result_checker: RTL and testbench
======================================

XNOR_RESULT_CHECKER -- requirements
Module: xnor_result_checker

Interface
REQ-001 Parameter: CNT_W, default 8, width of vector count, vector index and result counters.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  one-cycle pulse that begins a check run; honoured only in IDLE or DONE.
REQ-005 num_vec  input  CNT_W  number of vectors in the run; sampled on an accepted start.
REQ-006 in_valid  input  1  a, b and y carry a vector under check.
REQ-007 in_ready  output  1  checker accepts a vector this cycle.
REQ-008 a, b  input  8 each  operands applied to the device under check.
REQ-009 y  input  8  device output to be checked against XNOR(a, b).
REQ-010 busy  output  1  high in RUN and DRAIN.
REQ-011 done  output  1  high in DONE.
REQ-012 pass  output  1  high in DONE when fail_cnt = 0.
REQ-013 pass_cnt, fail_cnt  output  CNT_W each  matching and mismatching vector counts.
REQ-014 ff_valid  output  1  a first-failure record is held.
REQ-015 ff_idx  output  CNT_W  zero-based index of the first failing vector.
REQ-016 ff_a, ff_b, ff_y  output  8 each  operands and device output of the first failing vector.

Function
REQ-017 The block SHALL implement FSM states IDLE, RUN, DRAIN and DONE.
REQ-018 start in IDLE or DONE with num_vec > 0 SHALL clear counters, ff_valid and the vector index, then move to RUN.
REQ-019 start with num_vec = 0 SHALL move directly to DONE with both counters 0 and pass = 1.
REQ-020 start in RUN or DRAIN SHALL be ignored.
REQ-021 in_ready SHALL be 1 only in RUN; a vector is accepted when in_valid and in_ready are both 1.
REQ-022 On each accept, expected = ~(a ^ b) SHALL be computed and, with the vector and its index, registered into a single compare stage.
REQ-023 The registered compare SHALL update pass_cnt or fail_cnt one cycle after the accept (latency 1).
REQ-024 On the first mismatch of a run, ff_* SHALL capture the vector and ff_valid SHALL set; later mismatches SHALL NOT overwrite the record.
REQ-025 The accept of vector num_vec-1 SHALL move RUN to DRAIN; DRAIN SHALL last exactly one cycle, retire the final compare and then move to DONE.
REQ-026 in_valid low in RUN SHALL stall the run with no timeout; counters and the index SHALL hold.
REQ-027 DONE SHALL hold all results until the next accepted start or reset.
REQ-028 pass SHALL be 0 in every state except DONE.

Reset
REQ-029 rst SHALL asynchronously force IDLE and set every output and internal register to 0, including during RUN or DRAIN; in_ready SHALL be 0.
REQ-030 After rst deasserts, the first start SHALL be honoured on the next rising edge.

Structure
REQ-031 FSM state encoding and the 8-bit data-width constant SHALL live in a shared package, xnor_check_pkg.
REQ-032 The expected value SHALL come from one instance of the existing xnor_gate_8bit sub-module, used as the golden model.
REQ-033 No other sub-modules.

Verification
REQ-034 num_vec=4, vectors (00,00,FF) (FF,FF,FF) (AA,55,00) (F0,F0,FF), all correct -> done, pass=1, pass_cnt=4, fail_cnt=0, ff_valid=0.
REQ-035 num_vec=3, vector 1 = (0F,F0,FF) (expected 00), vector 2 = (3C,C3,01) (expected 00) -> fail_cnt=2, pass_cnt=1, ff_idx=1, ff_a=0F, ff_b=F0, ff_y=FF.
REQ-036 num_vec=0 start -> DONE on the next cycle, pass=1, both counters 0.
REQ-037 num_vec=2 with a 3-cycle in_valid gap between vectors -> counters hold during the gap, done only after the second accept plus DRAIN.
REQ-038 rst asserted mid-RUN after 1 of 4 vectors -> IDLE immediately, all outputs 0; a new start with num_vec=1 and vector (33,33,FF) -> pass=1.
REQ-039 start pulsed during RUN -> ignored, run completes with the original num_vec.

Source files
------------

// File: rtl/xnor_check_pkg.sv
// xnor_check_pkg: shared FSM encoding and data width for the XNOR result checker
package xnor_check_pkg;
    localparam int DATA_W = 8;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
endpackage

// File: rtl/xnor_result_checker_if.sv
// xnor_result_checker_if: run control, vector stream and result bus of the checker
// master: drives start/num_vec and the a/b/y vector stream, observes status and results
// slave: accepts vectors via in_ready, reports busy/done/pass, counters and first-failure record
interface xnor_result_checker_if #(parameter int CNT_W = 8);
    import xnor_check_pkg::*;
    logic              start;
    logic [CNT_W-1:0]  num_vec;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] y;
    logic              busy;
    logic              done;
    logic              pass;
    logic [CNT_W-1:0]  pass_cnt;
    logic [CNT_W-1:0]  fail_cnt;
    logic              ff_valid;
    logic [CNT_W-1:0]  ff_idx;
    logic [DATA_W-1:0] ff_a;
    logic [DATA_W-1:0] ff_b;
    logic [DATA_W-1:0] ff_y;
    modport master (
        output start, num_vec, in_valid, a, b, y,
        input  in_ready, busy, done, pass, pass_cnt, fail_cnt, ff_valid, ff_idx, ff_a, ff_b, ff_y
    );
    modport slave (
        input  start, num_vec, in_valid, a, b, y,
        output in_ready, busy, done, pass, pass_cnt, fail_cnt, ff_valid, ff_idx, ff_a, ff_b, ff_y
    );
endinterface

// File: rtl/xnor_gate_8bit.sv
// xnor_gate_8bit: golden bitwise XNOR model
// i_a, i_b: operands; o_y: ~(i_a ^ i_b)
module xnor_gate_8bit
    import xnor_check_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_y
);
    assign o_y = ~(i_a ^ i_b);
endmodule

// File: rtl/xnor_result_checker.sv
// xnor_result_checker: checks a stream of (a, b, y) vectors against XNOR(a, b)
// clk, rst: clock and async active-high reset; bus: slave side of xnor_result_checker_if
module xnor_result_checker
    import xnor_check_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic rst,
    xnor_result_checker_if.slave bus
);
    state_t            r_state, w_next;
    logic [CNT_W-1:0]  r_num, r_idx, r_pass_cnt, r_fail_cnt, r_ff_idx, r_cmp_idx;
    logic              r_cmp_vld, r_ff_valid;
    logic [DATA_W-1:0] r_cmp_a, r_cmp_b, r_cmp_y, r_cmp_exp, r_ff_a, r_ff_b, r_ff_y;
    logic [DATA_W-1:0] w_exp;
    logic              w_start_ok, w_acc, w_last, w_mis;

    xnor_gate_8bit u_gold (.i_a(bus.a), .i_b(bus.b), .o_y(w_exp));

    assign w_start_ok = bus.start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_acc      = bus.in_valid && r_state == S_RUN;
    assign w_last     = r_idx == r_num - CNT_W'(1);
    assign w_mis      = r_cmp_y != r_cmp_exp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        bus.in_ready = r_state == S_RUN;
        bus.busy     = r_state == S_RUN || r_state == S_DRAIN;
        bus.done     = r_state == S_DONE;
        bus.pass     = r_state == S_DONE && r_fail_cnt == '0;
        if (w_start_ok)                            w_next = bus.num_vec == '0 ? S_DONE : S_RUN;
        else if (w_acc && w_last)                  w_next = S_DRAIN;
        else if (r_state == S_DRAIN)               w_next = S_DONE;
    end

    // Single compare stage: the accepted vector and its expected value are
    // registered, then retired into the counters on the following edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_num      <= '0;
            r_idx      <= '0;
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_ff_valid <= 1'b0;
            r_ff_idx   <= '0;
            r_ff_a     <= '0;
            r_ff_b     <= '0;
            r_ff_y     <= '0;
            r_cmp_vld  <= 1'b0;
            r_cmp_idx  <= '0;
            r_cmp_a    <= '0;
            r_cmp_b    <= '0;
            r_cmp_y    <= '0;
            r_cmp_exp  <= '0;
        end else begin
            r_cmp_vld <= w_acc;
            if (w_acc) begin
                r_cmp_idx <= r_idx;
                r_cmp_a   <= bus.a;
                r_cmp_b   <= bus.b;
                r_cmp_y   <= bus.y;
                r_cmp_exp <= w_exp;
                r_idx     <= r_idx + CNT_W'(1);
            end
            if (w_start_ok) begin
                r_num      <= bus.num_vec;
                r_idx      <= '0;
                r_pass_cnt <= '0;
                r_fail_cnt <= '0;
                r_ff_valid <= 1'b0;
            end else if (r_cmp_vld) begin
                r_pass_cnt <= w_mis ? r_pass_cnt : r_pass_cnt + CNT_W'(1);
                r_fail_cnt <= w_mis ? r_fail_cnt + CNT_W'(1) : r_fail_cnt;
                if (w_mis && !r_ff_valid) begin
                    r_ff_valid <= 1'b1;
                    r_ff_idx   <= r_cmp_idx;
                    r_ff_a     <= r_cmp_a;
                    r_ff_b     <= r_cmp_b;
                    r_ff_y     <= r_cmp_y;
                end
            end
        end
    end

    assign bus.pass_cnt = r_pass_cnt;
    assign bus.fail_cnt = r_fail_cnt;
    assign bus.ff_valid = r_ff_valid;
    assign bus.ff_idx   = r_ff_idx;
    assign bus.ff_a     = r_ff_a;
    assign bus.ff_b     = r_ff_b;
    assign bus.ff_y     = r_ff_y;
endmodule

// File: tb/tb_xnor_result_checker.sv
// tb_xnor_result_checker: directed and random runs checked against a vector-list reference model
module tb_xnor_result_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errs = 0;
    int   checks = 0;
    logic [7:0] va [16];
    logic [7:0] vb [16];
    logic [7:0] vy [16];

    xnor_result_checker_if #(.CNT_W(8)) bus ();
    xnor_result_checker #(.CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit bad(input int i);
        logic [7:0] e;
        e = 8'hFF ^ va[i] ^ vb[i];
        return e != vy[i];
    endfunction

    function automatic int n_fail(input int k);
        int f = 0;
        for (int i = 0; i < k; i++) f += bad(i) ? 1 : 0;
        return f;
    endfunction

    function automatic int first_fail(input int k);
        for (int i = 0; i < k; i++) if (bad(i)) return i;
        return -1;
    endfunction

    task automatic set(input int i, input logic [7:0] a, input logic [7:0] b, input logic [7:0] y);
        va[i] = a;
        vb[i] = b;
        vy[i] = y;
    endtask

    task automatic chk_cnt(input string tag, input int k);
        chk({tag, "_pass_cnt"}, 32'(bus.pass_cnt), 32'(k - n_fail(k)));
        chk({tag, "_fail_cnt"}, 32'(bus.fail_cnt), 32'(n_fail(k)));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
        chk({tag, "_pass"}, 32'(bus.pass), 0);
        chk({tag, "_ready"}, 32'(bus.in_ready), 0);
        chk({tag, "_pcnt"}, 32'(bus.pass_cnt), 0);
        chk({tag, "_fcnt"}, 32'(bus.fail_cnt), 0);
        chk({tag, "_ffv"}, 32'(bus.ff_valid), 0);
        chk({tag, "_ffidx"}, 32'(bus.ff_idx), 0);
        chk({tag, "_ffa"}, 32'(bus.ff_a), 0);
        chk({tag, "_ffb"}, 32'(bus.ff_b), 0);
        chk({tag, "_ffy"}, 32'(bus.ff_y), 0);
    endtask

    task automatic start_run(input int n);
        bus.start   = 1'b1;
        bus.num_vec = 8'(n);
        tick();
        bus.start   = 1'b0;
    endtask

    task automatic feed(input int i, input bool_pulse, input int n);
        bus.in_valid = 1'b1;
        bus.a = va[i];
        bus.b = vb[i];
        bus.y = vy[i];
        if (bool_pulse) begin
            bus.start   = 1'b1;
            bus.num_vec = 8'(n + 3);
        end
        chk("in_ready_run", 32'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        bus.a = 8'($urandom);
        bus.b = 8'($urandom);
        bus.y = 8'($urandom);
    endtask

    // gap < 0 selects a random 0..2 cycle idle gap between vectors
    task automatic do_run(input string tag, input int n, input int gap, input bit pulse);
        int g, ff;
        start_run(n);
        if (n == 0) begin
            chk({tag, "_done"}, 32'(bus.done), 1);
            chk({tag, "_pass"}, 32'(bus.pass), 1);
            chk({tag, "_busy"}, 32'(bus.busy), 0);
            chk_cnt(tag, 0);
            return;
        end
        chk({tag, "_busy"}, 32'(bus.busy), 1);
        chk({tag, "_pass_run"}, 32'(bus.pass), 0);
        for (int i = 0; i < n; i++) begin
            feed(i, pulse && i == 1, n);
            chk_cnt({tag, "_lat"}, i);
            if (i < n - 1) begin
                g = gap < 0 ? int'($urandom_range(2, 0)) : gap;
                repeat (g) begin
                    tick();
                    chk_cnt({tag, "_gap"}, i + 1);
                    chk({tag, "_gap_done"}, 32'(bus.done), 0);
                end
            end
        end
        chk({tag, "_drain_busy"}, 32'(bus.busy), 1);
        chk({tag, "_drain_ready"}, 32'(bus.in_ready), 0);
        chk({tag, "_drain_done"}, 32'(bus.done), 0);
        tick();
        ff = first_fail(n);
        repeat (2) begin
            chk({tag, "_done"}, 32'(bus.done), 1);
            chk({tag, "_busy_done"}, 32'(bus.busy), 0);
            chk({tag, "_pass"}, 32'(bus.pass), 32'(ff < 0));
            chk_cnt({tag, "_end"}, n);
            chk({tag, "_ffv"}, 32'(bus.ff_valid), 32'(ff >= 0));
            if (ff >= 0) begin
                chk({tag, "_ffidx"}, 32'(bus.ff_idx), 32'(ff));
                chk({tag, "_ffa"}, 32'(bus.ff_a), 32'(va[ff]));
                chk({tag, "_ffb"}, 32'(bus.ff_b), 32'(vb[ff]));
                chk({tag, "_ffy"}, 32'(bus.ff_y), 32'(vy[ff]));
            end
            tick();
        end
    endtask

    initial begin
        int n;
        logic [7:0] e;
        bus.start = 1'b0;
        bus.num_vec = '0;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.y = '0;
        tick();
        tick();
        chk_zero("reset");
        rst = 1'b0;
        set(0, 8'h00, 8'h00, 8'hFF);
        set(1, 8'hFF, 8'hFF, 8'hFF);
        set(2, 8'hAA, 8'h55, 8'h00);
        set(3, 8'hF0, 8'hF0, 8'hFF);
        do_run("all_ok", 4, 0, 1'b0);
        set(0, 8'h12, 8'h34, 8'hD9);
        set(1, 8'h0F, 8'hF0, 8'hFF);
        set(2, 8'h3C, 8'hC3, 8'h01);
        do_run("two_bad", 3, 1, 1'b0);
        do_run("zero", 0, 0, 1'b0);
        set(0, 8'h01, 8'h01, 8'hFF);
        set(1, 8'h80, 8'h7F, 8'h00);
        do_run("gap3", 2, 3, 1'b0);
        set(0, 8'h5A, 8'hA5, 8'h00);
        set(1, 8'hC0, 8'h0C, 8'h33);
        set(2, 8'h11, 8'h22, 8'h00);
        do_run("ign_start", 3, 0, 1'b1);
        set(0, 8'h00, 8'hFF, 8'h00);
        start_run(4);
        feed(0, 1'b0, 4);
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        tick();
        rst = 1'b0;
        set(0, 8'h33, 8'h33, 8'hFF);
        do_run("after_rst", 1, 0, 1'b0);
        for (int r = 0; r < 8; r++) begin
            n = int'($urandom_range(12, 1));
            for (int i = 0; i < n; i++) begin
                va[i] = 8'($urandom);
                vb[i] = 8'($urandom);
                e = 8'hFF ^ va[i] ^ vb[i];
                vy[i] = ($urandom_range(3, 0) == 0) ? e ^ 8'($urandom_range(255, 1)) : e;
            end
            do_run("random", n, -1, 1'b0);
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
